// File: rtl/mul_arbiter.sv
// Two-requester round-robin front end for a shared multiplier: grants one
// operation at a time, issues it, formats the result and returns it to the owner.
`timescale 1ns/1ps
module mul_arbiter #(
  parameter int unsigned RR_INIT = 0
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [1:0]    i_req_valid,
  output logic [1:0]    o_req_ready,
  input  logic [1:0]    i_req_mulw,
  input  logic [3:0]    i_req_signed,
  input  logic [1:0]    i_req_hi,
  input  logic [127:0]  i_req_a,
  input  logic [127:0]  i_req_b,
  input  logic [1:0]    i_req_flush,
  output logic [1:0]    o_resp_valid,
  input  logic [1:0]    i_resp_ready,
  output logic [63:0]   o_resp_data,
  output logic          o_mul_in_valid,
  output logic          o_mul_flush,
  output logic          o_mul_mulw,
  output logic [1:0]    o_mul_signed,
  output logic [63:0]   o_mul_multiplicand,
  output logic [63:0]   o_mul_multiplier,
  input  logic          i_mul_out_ready,
  input  logic          i_mul_out_valid,
  input  logic [63:0]   i_mul_result_hi,
  input  logic [63:0]   i_mul_result_lo
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP,
    S_DRAIN
  } state_t;

  localparam logic PTR_INIT = (RR_INIT != 0);

  state_t      r_state;
  state_t      w_next;
  logic        r_ptr;
  logic        r_owner;
  logic        r_mulw;
  logic        r_hi;
  logic [1:0]  r_signed;
  logic [63:0] r_a;
  logic [63:0] r_b;
  logic [63:0] r_resp_data;

  logic        w_grant;
  logic        w_gnt_id;
  logic        w_own_flush;
  logic        w_ptr_adv;
  logic        w_capture;
  logic [63:0] w_result;

  // req_ready is gated by reset so every output reads zero while reset is held
  assign w_grant     = i_rst_n && (r_state == S_IDLE) && i_mul_out_ready && (|i_req_valid);
  assign w_gnt_id    = (&i_req_valid) ? r_ptr : i_req_valid[1];
  assign w_own_flush = i_req_flush[r_owner];
  assign w_capture   = (r_state == S_WAIT) && i_mul_out_valid && !w_own_flush;
  assign w_result    = r_mulw ? {{32{i_mul_result_lo[31]}}, i_mul_result_lo[31:0]}
                              : (r_hi ? i_mul_result_hi : i_mul_result_lo);

  assign o_mul_mulw         = r_mulw;
  assign o_mul_signed       = r_signed;
  assign o_mul_multiplicand = r_a;
  assign o_mul_multiplier   = r_b;
  assign o_resp_data        = r_resp_data;

  always_comb begin
    w_next         = r_state;
    o_req_ready    = '0;
    o_resp_valid   = '0;
    o_mul_in_valid = 1'b0;
    o_mul_flush    = 1'b0;
    w_ptr_adv      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          o_req_ready[w_gnt_id] = 1'b1;
          w_next                = S_ISSUE;
        end
      end
      S_ISSUE: begin
        o_mul_in_valid = 1'b1;
        if (w_own_flush) begin
          o_mul_flush = 1'b1;
          w_next      = S_DRAIN;
        end else begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        // a flush racing the result needs no multiplier flush: just drop it
        if (w_own_flush && i_mul_out_valid) begin
          w_next    = S_IDLE;
          w_ptr_adv = 1'b1;
        end else if (w_own_flush) begin
          o_mul_flush = 1'b1;
          w_next      = S_DRAIN;
        end else if (i_mul_out_valid) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        o_resp_valid[r_owner] = 1'b1;
        if (w_own_flush || i_resp_ready[r_owner]) begin
          w_next    = S_IDLE;
          w_ptr_adv = 1'b1;
        end
      end
      S_DRAIN: begin
        if (i_mul_out_valid) begin
          w_next    = S_IDLE;
          w_ptr_adv = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= PTR_INIT;
      r_owner     <= 1'b0;
      r_mulw      <= 1'b0;
      r_hi        <= 1'b0;
      r_signed    <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_resp_data <= '0;
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        r_owner  <= w_gnt_id;
        r_mulw   <= w_gnt_id ? i_req_mulw[1]     : i_req_mulw[0];
        r_hi     <= w_gnt_id ? i_req_hi[1]       : i_req_hi[0];
        r_signed <= w_gnt_id ? i_req_signed[3:2] : i_req_signed[1:0];
        r_a      <= w_gnt_id ? i_req_a[127:64]   : i_req_a[63:0];
        r_b      <= w_gnt_id ? i_req_b[127:64]   : i_req_b[63:0];
      end
      if (w_capture) begin
        r_resp_data <= w_result;
      end
      if (w_ptr_adv) begin
        r_ptr <= ~r_owner;
      end
    end
  end

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameter RR_INIT, default 0, meaning: requester given priority first after reset (0 or 1).
REQ-002 clock  in  1  sole clock; all state changes on its rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 req_valid  in  2  per-requester operation valid; bit n belongs to requester n.
REQ-005 req_ready  out  2  per-requester accept; at most one bit high per cycle.
REQ-006 req_mulw  in  2  per-requester 32-bit (W) operation flag.
REQ-007 req_signed  in  4  per-requester signedness code; bits [2n+1:2n] belong to requester n; codes 2'b11, 2'b10, 2'b00.
REQ-008 req_hi  in  2  per-requester select; 1 returns high 64 bits, 0 returns low 64 bits.
REQ-009 req_a, req_b  in  128 each  per-requester multiplicand and multiplier; bits [64n+63:64n] belong to requester n.
REQ-010 req_flush  in  2  per-requester cancel of that requester's outstanding operation.
REQ-011 resp_valid  out  2  per-requester result valid; at most one bit high per cycle.
REQ-012 resp_ready  in  2  per-requester result accept.
REQ-013 resp_data  out  64  formatted result; meaningful only when a resp_valid bit is high.
REQ-014 mul_in_valid, mul_flush, mul_mulw  out  1 each  multiplier control.
REQ-015 mul_signed  out  2; mul_multiplicand, mul_multiplier  out  64 each  latched operands driven to the multiplier.
REQ-016 mul_out_ready, mul_out_valid  in  1 each; mul_result_hi, mul_result_lo  in  64 each  multiplier status and results.

Function
REQ-017 FSM states: IDLE, ISSUE, WAIT, RESP, DRAIN.
REQ-018 IDLE: when mul_out_ready=1 and any req_valid is high, the block grants exactly one requester via combinational req_ready, latches its operands, mulw, signed code, hi select and owner id, and moves to ISSUE.
REQ-019 Arbitration is round-robin: with both requesters valid, the grant goes to the requester indicated by the priority pointer; a lone valid requester is always granted.
REQ-020 The priority pointer moves to the non-owner only on RESP handshake completion or flush completion; its reset value is RR_INIT.
REQ-021 req_ready is 0 for both requesters in every state other than IDLE, and in IDLE while mul_out_ready=0.
REQ-022 ISSUE: mul_in_valid=1 for exactly one cycle with the latched operands; the next state is WAIT.
REQ-023 mul_in_valid is 0 in every other state.
REQ-024 Operand outputs hold the latched values from ISSUE until the next grant.
REQ-025 WAIT: on mul_out_valid=1, the block captures the formatted result and moves to RESP.
REQ-026 Result formatting: mulw=1 gives {32{lo[31]}, lo[31:0]}, ignoring hi select; mulw=0, hi=1 gives mul_result_hi; mulw=0, hi=0 gives mul_result_lo.
REQ-027 RESP: resp_valid[owner]=1 and resp_data is held stable until resp_ready[owner]=1, then the next state is IDLE.
REQ-028 A new grant is not possible in the same cycle as that RESP handshake.
REQ-029 Flush in ISSUE or WAIT: req_flush[owner]=1 pulses mul_flush for one cycle and moves to DRAIN; the ISSUE pulse still completes in that cycle.
REQ-030 DRAIN: the block waits for mul_out_valid, discards the result with no resp_valid, then goes to IDLE.
REQ-031 A flush that coincides with mul_out_valid in WAIT discards the result and goes directly to IDLE.
REQ-032 Flush in RESP drops the response (resp_valid low the next cycle) and goes to IDLE; flush has priority over a simultaneous resp_ready.
REQ-033 req_flush of the non-owner, or any flush in IDLE or DRAIN, has no effect.
REQ-034 Total latency from accept cycle T: mul_in_valid at T+1; resp_valid one cycle after mul_out_valid.

Reset
REQ-035 Assertion of reset forces, immediately: state IDLE, all outputs 0, operand registers 0, priority pointer RR_INIT.
REQ-036 Reset asserted mid-operation abandons the operation with no response.
REQ-037 The first grant after reset is possible on the first clock edge after reset deassertion.

Verification
REQ-038 Requester 0 sends a=3, b=5, mulw=0, hi=0, signed=00 -> exactly one mul_in_valid pulse; resp_valid[0] with resp_data=15.
REQ-039 Both requesters valid in the same cycle, RR_INIT=0, back-to-back operations -> grant order 0, 1, 0, 1; resp_valid never goes to the non-owner.
REQ-040 Requester 1 sends mulw=1, a=0x7FFFFFFF, b=2, signed=11 -> resp_data=0xFFFFFFFF_FFFFFFFE.
REQ-041 Requester 0 sends a=-1, b=-1, signed=11, hi=1 -> resp_data=0; the same operands with signed=00 -> resp_data=0xFFFFFFFF_FFFFFFFE.
REQ-042 req_flush[owner] asserted 5 cycles into WAIT -> one mul_flush pulse, no resp_valid, req_ready low until mul_out_valid is seen, then the next grant succeeds.
REQ-043 resp_ready held low for 10 cycles in RESP, then reset asserted mid-WAIT of the following operation -> resp_data stable for all 10 cycles; after reset, all outputs 0 and no response arrives.
